// File: rtl/axi_stom_resp_mux_s3_if.sv
// Slave-side R/B bundles, arbiter select/grant and master-side R/B for one master port.
// The master modport is the environment side; the slave modport is the mux itself.
interface axi_stom_resp_mux_s3_if #(
  parameter int NUM    = 3,
  parameter int W_MID  = 4,
  parameter int W_ID   = 4,
  parameter int W_DATA = 32
);
  localparam int W_SID = W_MID + W_ID;

  logic [(NUM+1)*W_SID-1:0]  S_RID;
  logic [(NUM+1)*W_DATA-1:0] S_RDATA;
  logic [(NUM+1)*2-1:0]      S_RRESP;
  logic [NUM:0]              S_RLAST;
  logic [NUM:0]              S_RVALID;
  logic [NUM:0]              S_RREADY;
  logic [(NUM+1)*W_SID-1:0]  S_BID;
  logic [(NUM+1)*2-1:0]      S_BRESP;
  logic [NUM:0]              S_BVALID;
  logic [NUM:0]              S_BREADY;
  logic [NUM:0]              RSELECT;
  logic [NUM:0]              BSELECT;
  logic [NUM:0]              RGRANT;
  logic [NUM:0]              BGRANT;
  logic [W_ID-1:0]           M_RID;
  logic [W_DATA-1:0]         M_RDATA;
  logic [1:0]                M_RRESP;
  logic                      M_RLAST;
  logic                      M_RVALID;
  logic                      M_RREADY;
  logic [W_ID-1:0]           M_BID;
  logic [1:0]                M_BRESP;
  logic                      M_BVALID;
  logic                      M_BREADY;

  modport master (
    output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID, S_BID, S_BRESP, S_BVALID,
    output RGRANT, BGRANT, M_RREADY, M_BREADY,
    input  S_RREADY, S_BREADY, RSELECT, BSELECT,
    input  M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID, M_BID, M_BRESP, M_BVALID
  );

  modport slave (
    input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID, S_BID, S_BRESP, S_BVALID,
    input  RGRANT, BGRANT, M_RREADY, M_BREADY,
    output S_RREADY, S_BREADY, RSELECT, BSELECT,
    output M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID, M_BID, M_BRESP, M_BVALID
  );
endinterface

// File: rtl/axi_stom_resp_mux_s3.sv
// Per-master response mux: ID-prefix select, grant-driven R/B muxing into 2-entry skid buffers.
// 1 cycle slave handshake to M_*VALID; input ready depends only on buffer state, never on M_*READY.
module axi_stom_resp_mux_s3_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;

  assign pop     = out_vld & out_rdy;
  assign in_rdy  = (state_q != FULL);
  assign out_vld = (state_q != EMPTY);
  assign out_dat = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_dat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_dat;
        end else if (push) begin
          skid_d  = in_dat;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Ready is low here, so only a pop can move the buffer.
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
endmodule

module axi_stom_resp_mux_s3 #(
  parameter int          NUM    = 3,
  parameter int          W_MID  = 4,
  parameter int unsigned MID    = 0,
  parameter int          W_ID   = 4,
  parameter int          W_DATA = 32
) (
  input logic                   ACLK,
  input logic                   ARESET,
  axi_stom_resp_mux_s3_if.slave bus
);
  localparam int               W_SID   = W_MID + W_ID;
  localparam logic [W_MID-1:0] MID_PFX = MID[W_MID-1:0];

  typedef struct packed {
    logic [W_ID-1:0]   id;
    logic [W_DATA-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_beat_t;

  typedef struct packed {
    logic [W_ID-1:0] id;
    logic [1:0]      resp;
  } b_beat_t;

  logic [NUM:0] r_sel, b_sel;
  r_beat_t      r_in, r_out;
  b_beat_t      b_in, b_out;
  logic         r_in_rdy, b_in_rdy;
  logic         r_push, b_push;

  always_comb begin
    r_sel = '0;
    b_sel = '0;
    for (int i = 0; i <= NUM; i++) begin
      r_sel[i] = (bus.S_RID[i*W_SID+W_ID +: W_MID] == MID_PFX);
      b_sel[i] = (bus.S_BID[i*W_SID+W_ID +: W_MID] == MID_PFX);
    end
  end

  assign bus.RSELECT = r_sel;
  assign bus.BSELECT = b_sel;

  // Scanning downward lets the lowest granted index win on a non-onehot grant.
  always_comb begin
    r_in = '0;
    b_in = '0;
    for (int i = NUM; i >= 0; i--) begin
      if (bus.RGRANT[i]) begin
        r_in.id   = bus.S_RID[i*W_SID +: W_ID];
        r_in.data = bus.S_RDATA[i*W_DATA +: W_DATA];
        r_in.resp = bus.S_RRESP[i*2 +: 2];
        r_in.last = bus.S_RLAST[i];
      end
      if (bus.BGRANT[i]) begin
        b_in.id   = bus.S_BID[i*W_SID +: W_ID];
        b_in.resp = bus.S_BRESP[i*2 +: 2];
      end
    end
  end

  assign bus.S_RREADY = bus.RGRANT & {(NUM+1){r_in_rdy}};
  assign bus.S_BREADY = bus.BGRANT & {(NUM+1){b_in_rdy}};
  assign r_push       = |(bus.RGRANT & bus.S_RVALID & bus.S_RREADY);
  assign b_push       = |(bus.BGRANT & bus.S_BVALID & bus.S_BREADY);

  axi_stom_resp_mux_s3_skid #(.W($bits(r_beat_t))) u_r_skid (
    .clk     (ACLK),
    .rst     (ARESET),
    .push    (r_push),
    .in_dat  (r_in),
    .in_rdy  (r_in_rdy),
    .out_vld (bus.M_RVALID),
    .out_rdy (bus.M_RREADY),
    .out_dat (r_out)
  );

  axi_stom_resp_mux_s3_skid #(.W($bits(b_beat_t))) u_b_skid (
    .clk     (ACLK),
    .rst     (ARESET),
    .push    (b_push),
    .in_dat  (b_in),
    .in_rdy  (b_in_rdy),
    .out_vld (bus.M_BVALID),
    .out_rdy (bus.M_BREADY),
    .out_dat (b_out)
  );

  assign bus.M_RID   = r_out.id;
  assign bus.M_RDATA = r_out.data;
  assign bus.M_RRESP = r_out.resp;
  assign bus.M_RLAST = r_out.last;
  assign bus.M_BID   = b_out.id;
  assign bus.M_BRESP = b_out.resp;
endmodule

// File: tb/tb_axi_stom_resp_mux_s3.sv
// Directed bench for axi_stom_resp_mux_s3 with MID=0 and default widths.
module tb_axi_stom_resp_mux_s3;
  localparam int NUM = 3, W_MID = 4, W_ID = 4, W_DATA = 32;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  axi_stom_resp_mux_s3_if #(.NUM(NUM), .W_MID(W_MID), .W_ID(W_ID), .W_DATA(W_DATA)) bus ();

  axi_stom_resp_mux_s3 #(.NUM(NUM), .W_MID(W_MID), .MID(0), .W_ID(W_ID), .W_DATA(W_DATA)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv_r(input int s, input logic [7:0] sid, input logic [31:0] d,
                       input logic [1:0] resp, input logic last, input logic v);
    bus.S_RID[s*8 +: 8]    = sid;
    bus.S_RDATA[s*32 +: 32] = d;
    bus.S_RRESP[s*2 +: 2]  = resp;
    bus.S_RLAST[s]         = last;
    bus.S_RVALID[s]        = v;
  endtask

  task automatic drv_b(input int s, input logic [7:0] sid, input logic [1:0] resp, input logic v);
    bus.S_BID[s*8 +: 8]   = sid;
    bus.S_BRESP[s*2 +: 2] = resp;
    bus.S_BVALID[s]       = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.S_RID    = {4{8'hF0}};
    bus.S_RDATA  = '0;
    bus.S_RRESP  = '0;
    bus.S_RLAST  = '0;
    bus.S_RVALID = '0;
    bus.S_BID    = {4{8'hF0}};
    bus.S_BRESP  = '0;
    bus.S_BVALID = '0;
    bus.RGRANT   = 4'b0010;
    bus.BGRANT   = 4'b0100;
    bus.M_RREADY = 1'b0;
    bus.M_BREADY = 1'b0;

    // Reset state
    #12;
    chk("rst_rvalid", 64'(bus.M_RVALID), 64'd0);
    chk("rst_bvalid", 64'(bus.M_BVALID), 64'd0);
    chk("rst_r_payload", {25'd0, bus.M_RID, bus.M_RDATA, bus.M_RRESP, bus.M_RLAST}, 64'd0);
    chk("rst_b_payload", {58'd0, bus.M_BID, bus.M_BRESP}, 64'd0);
    chk("rst_rready_follows_grant", 64'(bus.S_RREADY), 64'h2);
    chk("rst_bready_follows_grant", 64'(bus.S_BREADY), 64'h4);
    tick();
    rst = 1'b0;
    bus.RGRANT = '0;
    bus.BGRANT = '0;

    // Single read from slave 2
    tick();
    drv_r(2, 8'h05, 32'hA5A5_0001, 2'b00, 1'b1, 1'b1);
    bus.RGRANT   = 4'b0100;
    bus.M_RREADY = 1'b1;
    #1;
    chk("single_rselect", 64'(bus.RSELECT), 64'h4);
    chk("single_s_rready", 64'(bus.S_RREADY), 64'h4);
    tick();
    chk("single_rvalid", 64'(bus.M_RVALID), 64'd1);
    chk("single_rid", 64'(bus.M_RID), 64'h5);
    chk("single_rdata", 64'(bus.M_RDATA), 64'hA5A5_0001);
    chk("single_rlast", 64'(bus.M_RLAST), 64'd1);
    drv_r(2, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.RGRANT = '0;
    tick();
    chk("single_drained", 64'(bus.M_RVALID), 64'd0);

    // Back-pressure: 4-beat burst from slave 1 with M_RREADY low
    bus.M_RREADY = 1'b0;
    bus.RGRANT   = 4'b0010;
    drv_r(1, 8'h08, 32'hB000_0000, 2'b00, 1'b0, 1'b1);
    tick();
    chk("bp_b0_out", 64'(bus.M_RDATA), 64'hB000_0000);
    chk("bp_rdy_one", 64'(bus.S_RREADY), 64'h2);
    drv_r(1, 8'h09, 32'hB000_0001, 2'b00, 1'b0, 1'b1);
    tick();
    chk("bp_rdy_full", 64'(bus.S_RREADY), 64'h0);
    drv_r(1, 8'h0A, 32'hB000_0002, 2'b00, 1'b0, 1'b1);
    tick();
    chk("bp_still_full", 64'(bus.S_RREADY), 64'h0);
    chk("bp_hold_rdata", 64'(bus.M_RDATA), 64'hB000_0000);
    chk("bp_hold_rid", 64'(bus.M_RID), 64'h8);
    bus.M_RREADY = 1'b1;
    tick();
    chk("bp_b1", {31'd0, bus.M_RVALID, bus.M_RDATA}, 64'h1_B000_0001);
    tick();
    chk("bp_b2", {31'd0, bus.M_RVALID, bus.M_RDATA}, 64'h1_B000_0002);
    drv_r(1, 8'h0B, 32'hB000_0003, 2'b00, 1'b1, 1'b1);
    tick();
    chk("bp_b3", {31'd0, bus.M_RVALID, bus.M_RDATA}, 64'h1_B000_0003);
    chk("bp_b3_last", 64'(bus.M_RLAST), 64'd1);
    drv_r(1, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.RGRANT = '0;
    tick();
    chk("bp_drained", 64'(bus.M_RVALID), 64'd0);

    // Streaming 16 beats from slave 3 with M_RREADY high
    bus.RGRANT = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      drv_r(3, 8'(k), 32'hC000_0000 + 32'(k), 2'b00, (k == 15), 1'b1);
      #1;
      chk("stream_rdy", 64'(bus.S_RREADY), 64'h8);
      if (k > 0) begin
        chk("stream_beat", {31'd0, bus.M_RVALID, bus.M_RDATA}, {31'd0, 1'b1, 32'hC000_0000 + 32'(k - 1)});
      end
      tick();
    end
    chk("stream_last", {60'd0, bus.M_RVALID, bus.M_RLAST, bus.M_RID[1:0]}, 64'hF);
    drv_r(3, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.RGRANT = '0;
    tick();
    chk("stream_drained", 64'(bus.M_RVALID), 64'd0);

    // ID filtering
    bus.S_RID = {8'h03, 8'hF0, 8'hF0, 8'h15};
    bus.S_BID = {8'h1F, 8'h31, 8'h2A, 8'h07};
    #1;
    chk("filt_rselect", 64'(bus.RSELECT), 64'h8);
    chk("filt_bselect", 64'(bus.BSELECT), 64'h1);
    bus.S_RID = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.S_BID = {8'h0F, 8'h41, 8'h0A, 8'h17};
    #1;
    chk("filt_rselect_all", 64'(bus.RSELECT), 64'hF);
    chk("filt_bselect_mix", 64'(bus.BSELECT), 64'hA);
    bus.S_RID = {4{8'hF0}};
    bus.S_BID = {4{8'hF0}};

    // Concurrent B from slave 0 and R from slave 3
    tick();
    bus.M_RREADY = 1'b0;
    bus.M_BREADY = 1'b0;
    drv_b(0, 8'h07, 2'b10, 1'b1);
    drv_r(3, 8'h03, 32'hD00D_0003, 2'b01, 1'b1, 1'b1);
    bus.BGRANT = 4'b0001;
    bus.RGRANT = 4'b1000;
    #1;
    chk("conc_s_bready", 64'(bus.S_BREADY), 64'h1);
    chk("conc_s_rready", 64'(bus.S_RREADY), 64'h8);
    tick();
    chk("conc_b", {57'd0, bus.M_BVALID, bus.M_BID, bus.M_BRESP}, {57'd0, 1'b1, 4'h7, 2'b10});
    chk("conc_r", {29'd0, bus.M_RVALID, bus.M_RID, bus.M_RDATA, bus.M_RRESP},
        {29'd0, 1'b1, 4'h3, 32'hD00D_0003, 2'b01});
    drv_b(0, 8'hF0, 2'b00, 1'b0);
    drv_r(3, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.BGRANT   = '0;
    bus.RGRANT   = '0;
    bus.M_BREADY = 1'b1;
    tick();
    chk("conc_b_popped", 64'(bus.M_BVALID), 64'd0);
    chk("conc_r_held", {31'd0, bus.M_RVALID, bus.M_RDATA}, 64'h1_D00D_0003);
    bus.M_RREADY = 1'b1;
    tick();
    chk("conc_r_popped", 64'(bus.M_RVALID), 64'd0);

    // Non-onehot grant resolves to lowest index; zero grant pushes nothing
    drv_r(1, 8'h01, 32'h1111_0001, 2'b00, 1'b0, 1'b1);
    drv_r(2, 8'h02, 32'h2222_0002, 2'b00, 1'b0, 1'b1);
    bus.RGRANT = 4'b0110;
    tick();
    chk("multi_grant_pick", {31'd0, bus.M_RVALID, bus.M_RDATA}, 64'h1_1111_0001);
    chk("multi_grant_id", 64'(bus.M_RID), 64'h1);
    drv_r(2, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.RGRANT = '0;
    #1;
    chk("zero_grant_rdy", 64'(bus.S_RREADY), 64'h0);
    tick();
    chk("zero_grant_no_push", 64'(bus.M_RVALID), 64'd0);
    drv_r(1, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Reset while FULL
    bus.M_RREADY = 1'b0;
    bus.RGRANT   = 4'b0010;
    drv_r(1, 8'h0E, 32'hE000_0000, 2'b00, 1'b0, 1'b1);
    tick();
    drv_r(1, 8'h0E, 32'hE000_0001, 2'b00, 1'b0, 1'b1);
    tick();
    chk("rstmid_full", 64'(bus.S_RREADY), 64'h0);
    drv_r(1, 8'h0F, 32'hF000_0000, 2'b11, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid", 64'(bus.M_RVALID), 64'd0);
    chk("rstmid_payload", {25'd0, bus.M_RID, bus.M_RDATA, bus.M_RRESP, bus.M_RLAST}, 64'd0);
    chk("rstmid_rready", 64'(bus.S_RREADY), 64'h2);
    tick();
    chk("rstmid_held", 64'(bus.M_RVALID), 64'd0);
    rst = 1'b0;
    tick();
    chk("rstmid_new_beat", {25'd0, bus.M_RID, bus.M_RDATA, bus.M_RRESP, bus.M_RLAST},
        {25'd0, 4'hF, 32'hF000_0000, 2'b11, 1'b1});
    chk("rstmid_new_valid", 64'(bus.M_RVALID), 64'd1);
    drv_r(1, 8'hF0, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.RGRANT   = '0;
    bus.M_RREADY = 1'b1;
    tick();
    chk("rstmid_drained", 64'(bus.M_RVALID), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_stom_resp_mux_s3.md
Name: axi_stom_resp_mux_s3

Overview:
- Downstream companion of the slave-to-master response arbiter, one instance per master port.
- Generates RSELECT/BSELECT by matching the upper (master-ID) bits of each slave's RID/BID against this master's ID, and feeds them to the arbiter.
- Consumes the arbiter's RGRANT/BGRANT, multiplexes the granted slave's R and B channels into independent 2-entry skid buffers, and drives the master-side R/B interfaces with registered outputs.

Parameters:
- NUM, 3: highest slave index; NUM+1 slave ports, numbered 0..NUM.
- W_MID, 4: width of the master-ID prefix carried in slave-side IDs.
- MID, 0: this master's ID; compared against the slave-side ID prefix.
- W_ID, 4: master-side transaction ID width. Slave-side ID width is W_SID = W_MID + W_ID.
- W_DATA, 32: read data width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- S_RID  in  (NUM+1)*W_SID  per-slave RID; slave i occupies slice i.
- S_RDATA  in  (NUM+1)*W_DATA  per-slave RDATA.
- S_RRESP  in  (NUM+1)*2  per-slave RRESP.
- S_RLAST  in  NUM+1  per-slave RLAST.
- S_RVALID  in  NUM+1  per-slave RVALID.
- S_RREADY  out  NUM+1  per-slave RREADY; also wired to the arbiter's RREADY.
- S_BID  in  (NUM+1)*W_SID  per-slave BID.
- S_BRESP  in  (NUM+1)*2  per-slave BRESP.
- S_BVALID  in  NUM+1  per-slave BVALID.
- S_BREADY  out  NUM+1  per-slave BREADY; also wired to the arbiter's BREADY.
- RSELECT  out  NUM+1  to arbiter.
- BSELECT  out  NUM+1  to arbiter.
- RGRANT  in  NUM+1  from arbiter.
- BGRANT  in  NUM+1  from arbiter.
- M_RID  out  W_ID  master RID (low W_ID bits of the slave RID).
- M_RDATA  out  W_DATA  master RDATA.
- M_RRESP  out  2  master RRESP.
- M_RLAST  out  1  master RLAST.
- M_RVALID  out  1  master RVALID.
- M_RREADY  in  1  master RREADY.
- M_BID  out  W_ID  master BID.
- M_BRESP  out  2  master BRESP.
- M_BVALID  out  1  master BVALID.
- M_BREADY  in  1  master BREADY.

Behaviour:
- Select generation (combinational):
  - RSELECT[i] = S_RID[i][W_SID-1:W_ID] == MID.
  - BSELECT[i] = S_BID[i][W_SID-1:W_ID] == MID.
  - Independent of VALID; the arbiter ANDs VALID itself.
- Grant decode:
  - Granted index = lowest set bit of RGRANT (BGRANT for B).
  - A non-onehot grant is a protocol error but is resolved deterministically by lowest index.
  - An all-zero grant means no source.
- Slave readiness:
  - S_RREADY[i] = RGRANT[i] & r_in_rdy, where r_in_rdy = (r_state != FULL).
  - r_in_rdy derives only from registered state; there is no combinational path from M_RREADY.
  - Same rule for B.
- Push/pop events:
  - R push = |(RGRANT & S_RVALID & S_RREADY).
  - R pop = M_RVALID & M_RREADY.
- Skid buffer (per channel): main slot drives the M_* outputs; skid slot holds overflow. States and transitions:
  - EMPTY: push -> capture into main, go ONE.
  - ONE: push & pop -> main <= input, stay ONE. Push only -> skid <= input, go FULL. Pop only -> go EMPTY.
  - FULL: pop -> main <= skid, go ONE. No push is possible because the ready is low.
- Latency and throughput:
  - 1 cycle from slave handshake to M_*VALID.
  - Sustains 1 beat/cycle while M_*READY stays high.
- Output stability: M_* payload is held stable while M_*VALID=1 and M_*READY=0.
- Data forwarding:
  - M_RID/M_BID = low W_ID bits of the captured slave ID.
  - RLAST is forwarded unchanged; the block does not count beats.
- Channel independence: R and B are fully independent; simultaneous events on both channels are legal.
- Reset (ARESET=1, asynchronous):
  - Both states go EMPTY.
  - M_RVALID=0, M_BVALID=0; all M_* payload outputs 0.
  - S_RREADY/S_BREADY follow the grant immediately after reset.
- Reset mid-burst: any buffered beats are discarded; the arbiter is reset by the same reset.
- Grant change while FULL: S_*READY is 0 for all slaves, so no beat is lost.

Test Plan:
- Single read, MID=0: slave 2 presents RID=0x05, RDATA=0xA5A5_0001, RLAST=1; RGRANT=4'b0100. Required: RSELECT=4'b0100, S_RREADY=4'b0100. Next cycle M_RVALID=1, M_RID=0x5, M_RDATA=0xA5A5_0001, M_RLAST=1.
- Back-pressure: 4-beat burst from slave 1 with M_RREADY=0. Required: 2 beats accepted, then S_RREADY=0. Raising M_RREADY delivers all 4 beats in order with no gaps thereafter.
- Streaming: M_RREADY held 1 throughout a 16-beat burst. Required: 16 consecutive M_RVALID cycles, 1-cycle latency, state never reaches FULL.
- ID filtering: slave 0 RID=0x15 (prefix 1), slave 3 RID=0x03 (prefix 0). Required: RSELECT=4'b1000 and BSELECT computed the same way from the BIDs.
- Concurrent channels: B response from slave 0 (BID=0x07, BRESP=2'b10) in the same cycle as an R beat from slave 3. Required: both appear next cycle, M_BID=0x7, M_BRESP=2'b10.
- Reset mid-burst: assert ARESET while state=FULL. Required: M_RVALID=0 within the same cycle, outputs zero; after release the first new beat appears 1 cycle after its handshake.
